ram_1w_1rs_sync: RTL and testbench
==================================

RAM_1W_1RS_SYNC -- requirements
Module: ram_1w_1rs_sync

Interface
REQ-001 SHALL take parameter wordCount, default 256, number of words.
REQ-002 SHALL take parameter wordWidth, default 32, bits per word.
REQ-003 SHALL take parameter symbolWidth, default 8, bits per mask lane; wordWidth SHALL be an integer multiple of it.
REQ-004 SHALL take parameter addressWidth, default 8, address bits; 2**addressWidth SHALL be >= wordCount.
REQ-005 SHALL take parameter outputReg, default 0; value 1 adds one output pipeline stage.
REQ-006 SHALL have one clock; reset is synchronous and active-high: clk  in  1  sole clock, all logic on its rising edge.
REQ-007 SHALL have: reset  in  1  synchronous active-high reset.
REQ-008 SHALL have: wr_en  in  1  write request.
REQ-009 SHALL have: wr_mask  in  wordWidth/symbolWidth  per-lane write enable.
REQ-010 SHALL have: wr_addr  in  addressWidth  write address.
REQ-011 SHALL have: wr_data  in  wordWidth  write data.
REQ-012 SHALL have: rd_en  in  1  read request.
REQ-013 SHALL have: rd_addr  in  addressWidth  read address.
REQ-014 SHALL have: rd_data  out  wordWidth  read data.
REQ-015 SHALL have: rd_valid  out  1  one-cycle pulse, rd_data holds a new read result.
REQ-016 SHALL have: init_busy  out  1  high while post-reset clear runs.

Function
REQ-017 FSM states SHALL be INIT and RUN only.
REQ-018 In INIT, an internal counter SHALL write all-zero to address 0, 1, ..., wordCount-1, one address per cycle, all lanes.
REQ-019 INIT SHALL last exactly wordCount cycles after reset deasserts, then transition to RUN; init_busy SHALL be 1 in INIT, 0 in RUN.
REQ-020 In INIT, wr_en and rd_en SHALL be ignored; rd_valid SHALL stay 0.
REQ-021 In RUN, on wr_en, lane i of word wr_addr SHALL be written from wr_data lane i only where wr_mask[i]=1.
REQ-022 In RUN, rd_en SHALL produce rd_valid=1 and the word on rd_data 1 cycle later (outputReg=0) or 2 cycles later (outputReg=1); one read accepted per cycle, fully pipelined.
REQ-023 rd_data SHALL hold its last value while rd_valid=0.
REQ-024 Write with wr_addr >= wordCount SHALL be dropped; read with rd_addr >= wordCount SHALL return all-zero with rd_valid=1.
REQ-025 Read and write to different addresses in one cycle SHALL both complete independently.
REQ-026 Same-address read and write in one cycle: see REQ-031/REQ-032.

Reset
REQ-027 Reset SHALL force state INIT, init counter 0, init_busy 1, rd_valid 0, rd_data 0, pipeline stages cleared.
REQ-028 Reset asserted mid-INIT SHALL restart the clear from address 0.
REQ-029 Reset asserted in RUN SHALL drop any in-flight read (no rd_valid pulse afterwards) and re-clear memory.
REQ-030 Reset SHALL take effect only on a clk rising edge.

Configuration
REQ-031 With macro RAM_1W_1RS_SYNC_BYPASS_EN defined, a same-cycle same-address read SHALL return, per lane, wr_data where wr_mask=1 and stored data otherwise (write-first).
REQ-032 Without RAM_1W_1RS_SYNC_BYPASS_EN, a same-cycle same-address read SHALL return the stored data before the write (read-first); no bypass logic SHALL be present.

Verification (wordCount=16, wordWidth=32, symbolWidth=8)
REQ-033 Release reset -> init_busy=1 for exactly 16 cycles, then 0; read all 16 addresses -> 0x00000000 each, rd_valid pulses per read.
REQ-034 Write addr 3 data 0xAABBCCDD mask 0xF, then addr 3 data 0x11223344 mask 0x5; read addr 3 -> 0xAA22CC44 after 1 cycle (outputReg=0) and 2 cycles (outputReg=1).
REQ-035 Addr 5 holds 0x12345678; same cycle write addr 5 data 0xFFFFFFFF mask 0x3 and read addr 5 -> 0x1234FFFF with macro, 0x12345678 without.
REQ-036 Back-to-back reads addr 0..15 on consecutive cycles -> 16 consecutive rd_valid pulses, data in order.
REQ-037 Assert reset at INIT cycle 7, release -> init_busy=1 for a full 16 further cycles; rd_en during INIT -> rd_valid stays 0.
REQ-038 Write addr 20 (out of range, addressWidth=5) -> no word changes; read addr 20 -> 0x00000000 with rd_valid=1.

Source files
------------

// File: rtl/ram_1w_1rs_sync.sv
// ram_1w_1rs_sync: one-write / one-read synchronous RAM with per-lane write mask,
// self-clearing after reset (INIT walks every address writing zero), optional
// extra output register stage (outputReg=1).
// Optional feature macro: RAM_1W_1RS_SYNC_BYPASS_EN -- same-cycle same-address
// read returns the freshly written lanes (write-first). Without it the read
// returns the word as stored before the write (read-first).
module ram_1w_1rs_sync #(
    parameter int unsigned wordCount    = 256,
    parameter int unsigned wordWidth    = 32,
    parameter int unsigned symbolWidth  = 8,
    parameter int unsigned addressWidth = 8,
    parameter int unsigned outputReg    = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               wr_en,
    input  logic [wordWidth/symbolWidth-1:0]   wr_mask,
    input  logic [addressWidth-1:0]            wr_addr,
    input  logic [wordWidth-1:0]               wr_data,
    input  logic                               rd_en,
    input  logic [addressWidth-1:0]            rd_addr,
    output logic [wordWidth-1:0]               rd_data,
    output logic                               rd_valid,
    output logic                               init_busy
);

    localparam int unsigned LANES = wordWidth / symbolWidth;
    localparam int unsigned IDX_W = (wordCount > 1) ? $clog2(wordCount) : 1;
    localparam logic [addressWidth:0] WORD_LIMIT = (addressWidth + 1)'(wordCount);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(wordCount - 1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [IDX_W-1:0]       init_cnt;
    logic [wordWidth-1:0]   mem [wordCount];

    logic                   wr_in_range;
    logic                   rd_in_range;
    logic [IDX_W-1:0]       wr_idx;
    logic [IDX_W-1:0]       rd_idx;
    logic                   wr_fire;
    logic                   rd_fire;
    logic [wordWidth-1:0]   rd_word_c;

    // Address decode; out-of-range accesses never touch the array.
    assign wr_in_range = {1'b0, wr_addr} < WORD_LIMIT;
    assign rd_in_range = {1'b0, rd_addr} < WORD_LIMIT;
    assign wr_idx      = IDX_W'(wr_addr);
    assign rd_idx      = IDX_W'(rd_addr);
    assign wr_fire     = (state_q == RUN) && wr_en && wr_in_range;
    assign rd_fire     = (state_q == RUN) && rd_en;

    // Next-state logic: INIT ends after the last address has been cleared.
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (init_cnt == LAST_IDX) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // State register, clear counter and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= INIT;
            init_cnt  <= '0;
            init_busy <= 1'b1;
        end else begin
            state_q   <= state_d;
            init_cnt  <= (state_d == INIT) ? init_cnt + IDX_W'(1) : '0;
            init_busy <= (state_d == INIT);
        end
    end

    // Storage array: zero fill during INIT, masked lane writes during RUN.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == INIT) begin
                mem[init_cnt] <= '0;
            end else if (wr_fire) begin
                for (int i = 0; i < LANES; i++) begin
                    if (wr_mask[i]) begin
                        mem[wr_idx][i*symbolWidth +: symbolWidth] <= wr_data[i*symbolWidth +: symbolWidth];
                    end
                end
            end
        end
    end

    // Read word selection, zero for out-of-range addresses.
    always_comb begin
        rd_word_c = '0;
        if (rd_in_range) begin
            rd_word_c = mem[rd_idx];
`ifdef RAM_1W_1RS_SYNC_BYPASS_EN
            if (wr_fire && (wr_addr == rd_addr)) begin
                for (int i = 0; i < LANES; i++) begin
                    if (wr_mask[i]) begin
                        rd_word_c[i*symbolWidth +: symbolWidth] = wr_data[i*symbolWidth +: symbolWidth];
                    end
                end
            end
`endif
        end
    end

    generate
        if (outputReg != 0) begin : g_out_reg
            logic                 pipe_valid;
            logic [wordWidth-1:0] pipe_data;

            // Two-stage read pipeline; rd_data only changes on a valid result.
            always_ff @(posedge clk) begin
                if (reset) begin
                    pipe_valid <= 1'b0;
                    pipe_data  <= '0;
                    rd_valid   <= 1'b0;
                    rd_data    <= '0;
                end else begin
                    pipe_valid <= rd_fire;
                    if (rd_fire) pipe_data <= rd_word_c;
                    rd_valid   <= pipe_valid;
                    if (pipe_valid) rd_data <= pipe_data;
                end
            end
        end else begin : g_out_direct
            // Single-stage read; rd_data only changes on a valid result.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    rd_valid <= rd_fire;
                    if (rd_fire) rd_data <= rd_word_c;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ram_1w_1rs_sync.sv
// Bench for ram_1w_1rs_sync (16 x 32-bit, 8-bit lanes, 5 address bits).
// Reference model: plain word array plus a read-result delay line.
module tb_ram_1w_1rs_sync;

    localparam int WC = 16;
    parameter int unsigned OUT_REG = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_mask = '0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        init_busy;

    always #5 clk = ~clk;

    ram_1w_1rs_sync #(
        .wordCount(16), .wordWidth(32), .symbolWidth(8), .addressWidth(5), .outputReg(OUT_REG)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_mask(wr_mask), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .init_busy(init_busy)
    );

    int total = 0;
    int bad = 0;

    logic [31:0] mdl [WC];
    bit          mdl_busy = 1'b0;
    int          init_left = 0;
    bit          pv = 1'b0;
    logic [31:0] pd = '0;
    bit          exp_valid = 1'b0;
    logic [31:0] exp_data = '0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (m[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    // Drive one cycle, advance the model across the rising edge, sample 1ns later.
    task automatic step(input bit r, input bit we, input logic [3:0] m, input logic [4:0] wa,
                        input logic [31:0] wd, input bit re, input logic [4:0] ra);
        bit          nv;
        logic [31:0] nd;
        reset = r; wr_en = we; wr_mask = m; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
        @(posedge clk);
        nv = 1'b0;
        nd = '0;
        if (r) begin
            mdl_busy = 1'b1; init_left = WC; pv = 1'b0; pd = '0; exp_valid = 1'b0; exp_data = '0;
        end else begin
            if (mdl_busy) begin
                mdl[WC - init_left] = '0;
                init_left--;
                mdl_busy = (init_left != 0);
            end else begin
                if (re) begin
                    nv = 1'b1;
                    if (int'(ra) < WC) begin
                        nd = mdl[ra[3:0]];
`ifdef RAM_1W_1RS_SYNC_BYPASS_EN
                        if (we && wa == ra) nd = merge(nd, wd, m);
`endif
                    end
                end
                if (we && int'(wa) < WC) mdl[wa[3:0]] = merge(mdl[wa[3:0]], wd, m);
            end
            if (OUT_REG != 0) begin
                exp_valid = pv;
                if (pv) exp_data = pd;
                pv = nv;
                if (nv) pd = nd;
            end else begin
                exp_valid = nv;
                if (nv) exp_data = nd;
            end
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0);
    endtask

    task automatic finish_init();
        for (int c = 0; c < 40 && init_busy === 1'b1; c++) idle();
        total++;
        if (init_busy !== 1'b0) begin
            bad++;
            $display("FAIL init_timeout: init_busy=%0b required 0", init_busy);
        end
    endtask

    task automatic test_reset();
        int n;
        int nv;
        step(1'b1, 1'b0, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        step(1'b1, 1'b1, 4'hF, 5'd1, 32'hDEAD, 1'b1, 5'd1);
        total++;
        if (init_busy !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: busy=%0b valid=%0b data=%h required 1 0 00000000", init_busy, rd_valid, rd_data);
        end
        n = 1;
        for (int c = 0; c < 40 && init_busy === 1'b1; c++) begin
            step(1'b0, 1'($urandom), 4'($urandom), 5'($urandom_range(0, 15)), $urandom, 1'b1, 5'($urandom_range(0, 15)));
            total++;
            if (rd_valid !== 1'b0 || init_busy !== mdl_busy) begin
                bad++;
                $display("FAIL init_ignore: valid=%0b busy=%0b required 0 %0b", rd_valid, init_busy, mdl_busy);
            end
            if (init_busy === 1'b1) n++;
        end
        total++;
        if (n != 16) begin
            bad++;
            $display("FAIL init_length: busy cycles=%0d required 16", n);
        end
        nv = 0;
        for (int a = 0; a < WC + 2; a++) begin
            if (a < WC) step(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b1, 5'(a));
            else idle();
            if (rd_valid === 1'b1) nv++;
            total++;
            if (rd_valid !== exp_valid || rd_data !== exp_data || (rd_valid === 1'b1 && rd_data !== 32'h0)) begin
                bad++;
                $display("FAIL cleared_read: valid=%0b data=%h required %0b %h", rd_valid, rd_data, exp_valid, exp_data);
            end
        end
        total++;
        if (nv != 16) begin
            bad++;
            $display("FAIL cleared_pulses: pulses=%0d required 16", nv);
        end
    endtask

    task automatic test_mask();
        step(1'b0, 1'b1, 4'hF, 5'd3, 32'hAABBCCDD, 1'b0, 5'd0);
        step(1'b0, 1'b1, 4'h5, 5'd3, 32'h11223344, 1'b0, 5'd0);
        step(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b1, 5'd3);
        repeat (OUT_REG) idle();
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 32'hAA22CC44) begin
            bad++;
            $display("FAIL mask_read: valid=%0b data=%h required 1 aa22cc44", rd_valid, rd_data);
        end
        idle();
        total++;
        if (rd_valid !== 1'b0 || rd_data !== 32'hAA22CC44) begin
            bad++;
            $display("FAIL mask_hold: valid=%0b data=%h required 0 aa22cc44", rd_valid, rd_data);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] want;
`ifdef RAM_1W_1RS_SYNC_BYPASS_EN
        want = 32'h1234FFFF;
`else
        want = 32'h12345678;
`endif
        step(1'b0, 1'b1, 4'hF, 5'd5, 32'h12345678, 1'b0, 5'd0);
        step(1'b0, 1'b1, 4'h3, 5'd5, 32'hFFFFFFFF, 1'b1, 5'd5);
        repeat (OUT_REG) idle();
        total++;
        if (rd_valid !== 1'b1 || rd_data !== want) begin
            bad++;
            $display("FAIL same_addr: valid=%0b data=%h required 1 %h", rd_valid, rd_data, want);
        end
        step(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b1, 5'd5);
        repeat (OUT_REG) idle();
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h1234FFFF) begin
            bad++;
            $display("FAIL after_write: valid=%0b data=%h required 1 1234ffff", rd_valid, rd_data);
        end
    endtask

    task automatic test_back_to_back();
        int nv;
        for (int a = 0; a < WC; a++) step(1'b0, 1'b1, 4'hF, 5'(a), $urandom, 1'b0, 5'd0);
        nv = 0;
        for (int a = 0; a < WC + 2; a++) begin
            if (a < WC) step(1'b0, 1'b1, 4'($urandom), 5'((a + 8) % WC), $urandom, 1'b1, 5'(a));
            else idle();
            if (rd_valid === 1'b1) nv++;
            total++;
            if (rd_valid !== exp_valid || rd_data !== exp_data) begin
                bad++;
                $display("FAIL b2b_read: valid=%0b data=%h required %0b %h", rd_valid, rd_data, exp_valid, exp_data);
            end
        end
        total++;
        if (nv != 16) begin
            bad++;
            $display("FAIL b2b_pulses: pulses=%0d required 16", nv);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] snap [WC];
        int k;
        for (int a = 0; a < WC; a++) snap[a] = mdl[a];
        step(1'b0, 1'b1, 4'hF, 5'd20, $urandom, 1'b0, 5'd0);
        step(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b1, 5'd20);
        repeat (OUT_REG) idle();
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin
            bad++;
            $display("FAIL oor_read: valid=%0b data=%h required 1 00000000", rd_valid, rd_data);
        end
        k = 0;
        for (int a = 0; a < WC + 2; a++) begin
            if (a < WC) step(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b1, 5'(a));
            else idle();
            if (rd_valid === 1'b1 && k < WC) begin
                total++;
                if (rd_data !== snap[k]) begin
                    bad++;
                    $display("FAIL oor_nochange: addr=%0d data=%h required %h", k, rd_data, snap[k]);
                end
                k++;
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] wa;
        logic [4:0] ra;
        for (int c = 0; c < 400; c++) begin
            wa = 5'($urandom_range(0, 19));
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 19));
            step(1'b0, 1'($urandom), 4'($urandom), wa, $urandom, 1'($urandom), ra);
            total++;
            if (rd_valid !== exp_valid || rd_data !== exp_data || init_busy !== 1'b0) begin
                bad++;
                $display("FAIL random_cyc%0d: valid=%0b data=%h busy=%0b required %0b %h 0",
                         c, rd_valid, rd_data, init_busy, exp_valid, exp_data);
            end
        end
        repeat (2) idle();
    endtask

    task automatic test_reset_in_run();
        step(1'b0, 1'b1, 4'hF, 5'd2, 32'hCAFEF00D, 1'b0, 5'd0);
        step(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b1, 5'd2);
        step(1'b1, 1'b0, 4'h0, 5'd0, 32'h0, 1'b1, 5'd2);
        total++;
        if (rd_valid !== 1'b0 || rd_data !== 32'h0 || init_busy !== 1'b1) begin
            bad++;
            $display("FAIL run_reset: valid=%0b data=%h busy=%0b required 0 00000000 1", rd_valid, rd_data, init_busy);
        end
        for (int c = 0; c < 40 && init_busy === 1'b1; c++) begin
            step(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b1, 5'd2);
            total++;
            if (rd_valid !== 1'b0) begin
                bad++;
                $display("FAIL run_reset_drop: valid=%0b required 0", rd_valid);
            end
        end
        finish_init();
        step(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b1, 5'd2);
        repeat (OUT_REG) idle();
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin
            bad++;
            $display("FAIL reclear: valid=%0b data=%h required 1 00000000", rd_valid, rd_data);
        end
    endtask

    task automatic test_reset_mid_init();
        int n;
        step(1'b1, 1'b0, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        repeat (7) begin
            step(1'b0, 1'b1, 4'hF, 5'd4, $urandom, 1'b1, 5'($urandom_range(0, 15)));
            total++;
            if (rd_valid !== 1'b0 || init_busy !== 1'b1) begin
                bad++;
                $display("FAIL midinit_pre: valid=%0b busy=%0b required 0 1", rd_valid, init_busy);
            end
        end
        step(1'b1, 1'b0, 4'h0, 5'd0, 32'h0, 1'b1, 5'd0);
        n = 1;
        for (int c = 0; c < 40 && init_busy === 1'b1; c++) begin
            step(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b1, 5'($urandom_range(0, 15)));
            total++;
            if (rd_valid !== 1'b0) begin
                bad++;
                $display("FAIL midinit_read: valid=%0b required 0", rd_valid);
            end
            if (init_busy === 1'b1) n++;
        end
        total++;
        if (n != 16) begin
            bad++;
            $display("FAIL midinit_length: busy cycles=%0d required 16", n);
        end
        step(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b1, 5'd4);
        repeat (OUT_REG) idle();
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin
            bad++;
            $display("FAIL midinit_clear: valid=%0b data=%h required 1 00000000", rd_valid, rd_data);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_mask();
        test_bypass();
        test_back_to_back();
        test_out_of_range();
        test_random();
        test_reset_in_run();
        test_reset_mid_init();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
